// File: rtl/cacheline_adaptor.sv
// Bridges whole-line cache requests to a beat-oriented burst memory: reads assemble
// NB beats into a line buffer, write-backs stream a latched line out one beat at a time.
module cacheline_adaptor #(
   parameter int LINE_WIDTH  = 256,
   parameter int BURST_WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [31:0]            address_i,
   input  logic                   read_i,
   input  logic                   write_i,
   input  logic [LINE_WIDTH-1:0]  line_i,
   output logic [LINE_WIDTH-1:0]  line_o,
   output logic                   resp_o,
   output logic [31:0]            address_o,
   output logic                   read_o,
   output logic                   write_o,
   output logic [BURST_WIDTH-1:0] burst_o,
   input  logic [BURST_WIDTH-1:0] burst_i,
   input  logic                   resp_i,
   output logic [31:0]            rd_count_o,
   output logic [31:0]            wr_count_o
);

   localparam int NB          = LINE_WIDTH / BURST_WIDTH;
   localparam int BEAT_W      = (NB > 1) ? $clog2(NB) : 1;
   localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
   localparam logic [31:0]       ADDR_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NB - 1);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t                   state_reg, state_next;
   logic [31:0]              addr_reg;
   logic [LINE_WIDTH-1:0]    wline_reg;
   logic [LINE_WIDTH-1:0]    rline_reg;
   logic [BEAT_W-1:0]        beat_reg;
   logic [31:0]              rd_count_reg;
   logic [31:0]              wr_count_reg;
   logic                     in_burst;
   logic                     beat_fire;
   logic                     last_beat;
   logic [BURST_WIDTH-1:0]   wbeat [NB];

   assign in_burst  = (state_reg == READ) || (state_reg == WRITE);
   assign beat_fire = resp_i && in_burst;
   assign last_beat = beat_fire && (beat_reg == LAST_BEAT);

   // Write-back line viewed as an array of beats so burst_o is a plain mux.
   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_wbeat
         assign wbeat[gi] = wline_reg[gi*BURST_WIDTH +: BURST_WIDTH];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE: begin
            if (write_i)     state_next = WRITE;
            else if (read_i) state_next = READ;
         end
         READ, WRITE: begin
            if (last_beat) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_reg     <= '0;
         wline_reg    <= '0;
         rline_reg    <= '0;
         beat_reg     <= '0;
         rd_count_reg <= '0;
         wr_count_reg <= '0;
      end else begin
         if (state_reg == IDLE && (read_i || write_i)) begin
            addr_reg <= address_i;
            beat_reg <= '0;
            if (write_i) wline_reg <= line_i;
         end else if (beat_fire) begin
            beat_reg <= beat_reg + 1'b1;
         end

         // Read beats land directly in the line buffer, so line_o keeps the old
         // line until beat 0 of the next read overwrites it.
         if (state_reg == READ && resp_i) begin
            for (int k = 0; k < NB; k++) begin
               if (beat_reg == BEAT_W'(k))
                  rline_reg[k*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
            end
         end

         if (last_beat && state_reg == READ && rd_count_reg != 32'hFFFF_FFFF)
            rd_count_reg <= rd_count_reg + 32'd1;
         if (last_beat && state_reg == WRITE && wr_count_reg != 32'hFFFF_FFFF)
            wr_count_reg <= wr_count_reg + 32'd1;
      end
   end

   assign line_o     = rline_reg;
   assign resp_o     = (state_reg == DONE);
   assign read_o     = (state_reg == READ);
   assign write_o    = (state_reg == WRITE);
   assign address_o  = in_burst ? (addr_reg & ADDR_MASK) : 32'd0;
   assign burst_o    = (state_reg == WRITE) ? wbeat[beat_reg] : '0;
   assign rd_count_o = rd_count_reg;
   assign wr_count_o = wr_count_reg;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed scenarios plus randomized
// line transactions compared against a line-level reference model.
module tb_cacheline_adaptor;

   localparam int LW = 256;
   localparam int BW = 64;
   localparam int NB = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   address_i;
   logic          read_i;
   logic          write_i;
   logic [LW-1:0] line_i;
   logic [LW-1:0] line_o;
   logic          resp_o;
   logic [31:0]   address_o;
   logic          read_o;
   logic          write_o;
   logic [BW-1:0] burst_o;
   logic [BW-1:0] burst_i;
   logic          resp_i;
   logic [31:0]   rd_count_o;
   logic [31:0]   wr_count_o;

   int tests    = 0;
   int failures = 0;

   // Reference model state: completed line counts and the last line read.
   int            exp_rd    = 0;
   int            exp_wr    = 0;
   logic [LW-1:0] last_line = '0;

   cacheline_adaptor #(.LINE_WIDTH(LW), .BURST_WIDTH(BW)) dut (
      .clk        (clk),
      .rst        (rst),
      .address_i  (address_i),
      .read_i     (read_i),
      .write_i    (write_i),
      .line_i     (line_i),
      .line_o     (line_o),
      .resp_o     (resp_o),
      .address_o  (address_o),
      .read_o     (read_o),
      .write_o    (write_o),
      .burst_o    (burst_o),
      .burst_i    (burst_i),
      .resp_i     (resp_i),
      .rd_count_o (rd_count_o),
      .wr_count_o (wr_count_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] v;
      for (int i = 0; i < LW/32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Memory sees the start of the 32-byte line containing the address.
   function automatic logic [31:0] line_base(input logic [31:0] a);
      return a - (a % 32);
   endfunction

   function automatic logic [15:0] rand_gaps();
      logic [15:0] g;
      for (int k = 0; k < NB; k++) g[k*4 +: 4] = 4'($urandom_range(0, 2));
      return g;
   endfunction

   // Drives one line read; memory returns beat k = line[k*BW +: BW] after gaps[k*4 +: 4] idle cycles.
   task automatic run_read(input logic [31:0] addr, input logic [LW-1:0] line, input logic [15:0] gaps,
                           input bit hold, input bit stray,
                           output logic [31:0] o_addr, output int o_rd_low, output int o_resp_early,
                           output logic o_resp_done, output logic o_rd_done, output logic [LW-1:0] o_line,
                           output logic o_resp_after, output logic o_rd_after);
      address_i = addr;
      read_i    = 1'b1;
      write_i   = 1'b0;
      resp_i    = stray;
      burst_i   = {$urandom, $urandom};
      @(posedge clk); #1;
      if (!hold) read_i = 1'b0;
      address_i    = $urandom;
      resp_i       = 1'b0;
      o_addr       = address_o;
      o_rd_low     = 0;
      o_resp_early = 0;
      for (int k = 0; k < NB; k++) begin
         for (int g = 0; g < int'(gaps[k*4 +: 4]); g++) begin
            resp_i  = 1'b0;
            burst_i = {$urandom, $urandom};
            if (!read_o) o_rd_low++;
            if (resp_o)  o_resp_early++;
            @(posedge clk); #1;
         end
         resp_i  = 1'b1;
         burst_i = line[k*BW +: BW];
         if (!read_o) o_rd_low++;
         if (resp_o)  o_resp_early++;
         @(posedge clk); #1;
      end
      resp_i      = 1'b0;
      burst_i     = {$urandom, $urandom};
      o_resp_done = resp_o;
      o_rd_done   = read_o;
      o_line      = line_o;
      @(posedge clk); #1;
      o_resp_after = resp_o;
      o_rd_after   = read_o;
      $display("[TB] read  addr=%h line=%h", addr, line);
   endtask

   // Drives one write-back; captures burst_o on each accepted beat in acceptance order.
   task automatic run_write(input logic [31:0] addr, input logic [LW-1:0] line, input logic [15:0] gaps,
                            input bit both,
                            output logic [31:0] o_addr, output logic [LW-1:0] o_bursts, output int o_wr_low,
                            output int o_rd_high, output int o_resp_early, output logic o_resp_done,
                            output logic o_wr_done, output logic [31:0] o_addr_done,
                            output logic [BW-1:0] o_burst_done, output logic [LW-1:0] o_line_done,
                            output logic o_resp_after);
      address_i = addr;
      line_i    = line;
      write_i   = 1'b1;
      read_i    = both;
      resp_i    = 1'b0;
      @(posedge clk); #1;
      write_i      = 1'b0;
      read_i       = 1'b0;
      line_i       = rand_line();
      address_i    = $urandom;
      o_addr       = address_o;
      o_wr_low     = 0;
      o_rd_high    = 0;
      o_resp_early = 0;
      o_bursts     = '0;
      for (int k = 0; k < NB; k++) begin
         for (int g = 0; g < int'(gaps[k*4 +: 4]); g++) begin
            resp_i = 1'b0;
            if (!write_o) o_wr_low++;
            if (read_o)   o_rd_high++;
            if (resp_o)   o_resp_early++;
            @(posedge clk); #1;
         end
         resp_i = 1'b1;
         o_bursts[k*BW +: BW] = burst_o;
         if (!write_o) o_wr_low++;
         if (read_o)   o_rd_high++;
         if (resp_o)   o_resp_early++;
         @(posedge clk); #1;
      end
      resp_i       = 1'b0;
      o_resp_done  = resp_o;
      o_wr_done    = write_o;
      o_addr_done  = address_o;
      o_burst_done = burst_o;
      o_line_done  = line_o;
      if (read_o) o_rd_high++;
      @(posedge clk); #1;
      o_resp_after = resp_o;
      $display("[TB] write addr=%h line=%h", addr, line);
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      read_i    = 1'b1;
      write_i   = 1'b1;
      resp_i    = 1'b1;
      address_i = $urandom;
      line_i    = rand_line();
      burst_i   = {$urandom, $urandom};
      repeat (2) @(posedge clk);
      #1;
      tests++; if (resp_o !== 1'b0)     begin failures++; $display("FAIL reset_resp: got %b expected 0", resp_o); end
      tests++; if (read_o !== 1'b0)     begin failures++; $display("FAIL reset_read: got %b expected 0", read_o); end
      tests++; if (write_o !== 1'b0)    begin failures++; $display("FAIL reset_write: got %b expected 0", write_o); end
      tests++; if (address_o !== 32'd0) begin failures++; $display("FAIL reset_addr: got %h expected 0", address_o); end
      tests++; if (burst_o !== '0)      begin failures++; $display("FAIL reset_burst: got %h expected 0", burst_o); end
      tests++; if (line_o !== '0)       begin failures++; $display("FAIL reset_line: got %h expected 0", line_o); end
      tests++; if (rd_count_o !== 32'd0) begin failures++; $display("FAIL reset_rd_count: got %0d expected 0", rd_count_o); end
      tests++; if (wr_count_o !== 32'd0) begin failures++; $display("FAIL reset_wr_count: got %0d expected 0", wr_count_o); end
      rst     = 1'b0;
      read_i  = 1'b0;
      write_i = 1'b0;
      resp_i  = 1'b0;
   endtask

   // Starts on the first cycle after reset release, so it also covers immediate acceptance.
   task automatic test_read();
      logic [31:0] o_addr; int o_rd_low, o_resp_early; logic o_resp_done, o_rd_done, o_resp_after, o_rd_after;
      logic [LW-1:0] o_line, exp_line, lv;
      lv = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      exp_line = lv;
      run_read(32'h0000_1234, lv, 16'h0000, 1'b0, 1'b0, o_addr, o_rd_low, o_resp_early,
               o_resp_done, o_rd_done, o_line, o_resp_after, o_rd_after);
      exp_rd++; last_line = exp_line;
      tests++; if (o_addr !== 32'h0000_1220) begin failures++; $display("FAIL read_addr: got %h expected 00001220", o_addr); end
      tests++; if (o_rd_low !== 0)     begin failures++; $display("FAIL read_read_o_held: got %0d low cycles expected 0", o_rd_low); end
      tests++; if (o_resp_early !== 0) begin failures++; $display("FAIL read_resp_early: got %0d expected 0", o_resp_early); end
      tests++; if (o_resp_done !== 1'b1) begin failures++; $display("FAIL read_resp: got %b expected 1", o_resp_done); end
      tests++; if (o_rd_done !== 1'b0) begin failures++; $display("FAIL read_read_o_done: got %b expected 0", o_rd_done); end
      tests++; if (o_line !== exp_line) begin failures++; $display("FAIL read_line: got %h expected %h", o_line, exp_line); end
      tests++; if (o_resp_after !== 1'b0) begin failures++; $display("FAIL read_resp_pulse: got %b expected 0", o_resp_after); end
      tests++; if (rd_count_o !== 32'(exp_rd)) begin failures++; $display("FAIL read_rd_count: got %0d expected %0d", rd_count_o, exp_rd); end
      tests++; if (line_o !== exp_line) begin failures++; $display("FAIL read_line_hold: got %h expected %h", line_o, exp_line); end
   endtask

   task automatic test_write_gapped();
      logic [31:0] o_addr, o_addr_done; logic [LW-1:0] o_bursts, o_line_done, lv; logic [BW-1:0] o_burst_done;
      int o_wr_low, o_rd_high, o_resp_early; logic o_resp_done, o_wr_done, o_resp_after;
      lv = rand_line();
      // resp_i pattern 1,0,1,1,0,1: no gap before beats 0 and 2, one idle cycle before beats 1 and 3
      run_write(32'h0000_ABCD, lv, 16'h1010, 1'b0, o_addr, o_bursts, o_wr_low, o_rd_high, o_resp_early,
                o_resp_done, o_wr_done, o_addr_done, o_burst_done, o_line_done, o_resp_after);
      exp_wr++;
      tests++; if (o_addr !== line_base(32'h0000_ABCD)) begin failures++; $display("FAIL write_addr: got %h expected %h", o_addr, line_base(32'h0000_ABCD)); end
      tests++; if (o_bursts !== lv) begin failures++; $display("FAIL write_bursts: got %h expected %h", o_bursts, lv); end
      tests++; if (o_wr_low !== 0) begin failures++; $display("FAIL write_write_o_held: got %0d low cycles expected 0", o_wr_low); end
      tests++; if (o_resp_early !== 0) begin failures++; $display("FAIL write_resp_early: got %0d expected 0", o_resp_early); end
      tests++; if (o_resp_done !== 1'b1) begin failures++; $display("FAIL write_resp: got %b expected 1", o_resp_done); end
      tests++; if (o_wr_done !== 1'b0) begin failures++; $display("FAIL write_write_o_done: got %b expected 0", o_wr_done); end
      tests++; if (o_addr_done !== 32'd0) begin failures++; $display("FAIL write_addr_done: got %h expected 0", o_addr_done); end
      tests++; if (o_burst_done !== '0) begin failures++; $display("FAIL write_burst_done: got %h expected 0", o_burst_done); end
      tests++; if (o_line_done !== last_line) begin failures++; $display("FAIL write_line_kept: got %h expected %h", o_line_done, last_line); end
      tests++; if (o_resp_after !== 1'b0) begin failures++; $display("FAIL write_resp_pulse: got %b expected 0", o_resp_after); end
      tests++; if (wr_count_o !== 32'(exp_wr)) begin failures++; $display("FAIL write_wr_count: got %0d expected %0d", wr_count_o, exp_wr); end
   endtask

   task automatic test_simultaneous();
      logic [31:0] o_addr, o_addr_done; logic [LW-1:0] o_bursts, o_line_done, lv; logic [BW-1:0] o_burst_done;
      int o_wr_low, o_rd_high, o_resp_early; logic o_resp_done, o_wr_done, o_resp_after;
      lv = rand_line();
      run_write($urandom, lv, rand_gaps(), 1'b1, o_addr, o_bursts, o_wr_low, o_rd_high, o_resp_early,
                o_resp_done, o_wr_done, o_addr_done, o_burst_done, o_line_done, o_resp_after);
      exp_wr++;
      tests++; if (o_rd_high !== 0) begin failures++; $display("FAIL both_read_o: got %0d high cycles expected 0", o_rd_high); end
      tests++; if (o_bursts !== lv) begin failures++; $display("FAIL both_bursts: got %h expected %h", o_bursts, lv); end
      tests++; if (rd_count_o !== 32'(exp_rd)) begin failures++; $display("FAIL both_rd_count: got %0d expected %0d", rd_count_o, exp_rd); end
      tests++; if (wr_count_o !== 32'(exp_wr)) begin failures++; $display("FAIL both_wr_count: got %0d expected %0d", wr_count_o, exp_wr); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] o_addr; int o_rd_low, o_resp_early; logic o_resp_done, o_rd_done, o_resp_after, o_rd_after;
      logic [LW-1:0] o_line, lv;
      int resp_seen;
      address_i = $urandom;
      read_i    = 1'b1;
      @(posedge clk); #1;
      read_i = 1'b0;
      for (int k = 0; k < 2; k++) begin
         resp_i  = 1'b1;
         burst_i = {$urandom, $urandom};
         @(posedge clk); #1;
      end
      resp_i = 1'b0;
      rst    = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_rd = 0; exp_wr = 0; last_line = '0;
      tests++; if (read_o !== 1'b0) begin failures++; $display("FAIL rstmid_read_o: got %b expected 0", read_o); end
      tests++; if (line_o !== '0) begin failures++; $display("FAIL rstmid_line: got %h expected 0", line_o); end
      tests++; if (rd_count_o !== 32'd0) begin failures++; $display("FAIL rstmid_rd_count: got %0d expected 0", rd_count_o); end
      tests++; if (wr_count_o !== 32'd0) begin failures++; $display("FAIL rstmid_wr_count: got %0d expected 0", wr_count_o); end
      tests++; if (address_o !== 32'd0) begin failures++; $display("FAIL rstmid_addr: got %h expected 0", address_o); end
      resp_seen = 0;
      for (int c = 0; c < 4; c++) begin
         if (resp_o) resp_seen++;
         @(posedge clk); #1;
      end
      tests++; if (resp_seen !== 0) begin failures++; $display("FAIL rstmid_no_resp: got %0d pulses expected 0", resp_seen); end
      lv = rand_line();
      run_read($urandom, lv, rand_gaps(), 1'b0, 1'b0, o_addr, o_rd_low, o_resp_early,
               o_resp_done, o_rd_done, o_line, o_resp_after, o_rd_after);
      exp_rd++; last_line = lv;
      tests++; if (o_line !== lv) begin failures++; $display("FAIL rstmid_fresh_line: got %h expected %h", o_line, lv); end
      tests++; if (rd_count_o !== 32'(exp_rd)) begin failures++; $display("FAIL rstmid_fresh_count: got %0d expected %0d", rd_count_o, exp_rd); end
   endtask

   task automatic test_stray_resp();
      logic [31:0] o_addr; int o_rd_low, o_resp_early; logic o_resp_done, o_rd_done, o_resp_after, o_rd_after;
      logic [LW-1:0] o_line, lv;
      for (int c = 0; c < 3; c++) begin
         resp_i  = 1'b1;
         burst_i = {$urandom, $urandom};
         @(posedge clk); #1;
         tests++; if (line_o !== last_line) begin failures++; $display("FAIL stray_line_idle: got %h expected %h", line_o, last_line); end
      end
      resp_i = 1'b0;
      lv = rand_line();
      run_read($urandom, lv, rand_gaps(), 1'b0, 1'b1, o_addr, o_rd_low, o_resp_early,
               o_resp_done, o_rd_done, o_line, o_resp_after, o_rd_after);
      exp_rd++; last_line = lv;
      tests++; if (o_line !== lv) begin failures++; $display("FAIL stray_line: got %h expected %h", o_line, lv); end
      tests++; if (o_resp_done !== 1'b1) begin failures++; $display("FAIL stray_resp: got %b expected 1", o_resp_done); end
      tests++; if (rd_count_o !== 32'(exp_rd)) begin failures++; $display("FAIL stray_rd_count: got %0d expected %0d", rd_count_o, exp_rd); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] o_addr, a1, a2; int o_rd_low, o_resp_early; logic o_resp_done, o_rd_done, o_resp_after, o_rd_after;
      logic [LW-1:0] o_line, l1, l2;
      a1 = $urandom; a2 = $urandom;
      l1 = rand_line(); l2 = rand_line();
      run_read(a1, l1, rand_gaps(), 1'b1, 1'b0, o_addr, o_rd_low, o_resp_early,
               o_resp_done, o_rd_done, o_line, o_resp_after, o_rd_after);
      exp_rd++;
      tests++; if (o_line !== l1) begin failures++; $display("FAIL b2b_line1: got %h expected %h", o_line, l1); end
      tests++; if (o_rd_after !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap: got read_o=%b expected 0", o_rd_after); end
      run_read(a2, l2, rand_gaps(), 1'b0, 1'b0, o_addr, o_rd_low, o_resp_early,
               o_resp_done, o_rd_done, o_line, o_resp_after, o_rd_after);
      exp_rd++; last_line = l2;
      tests++; if (o_rd_low !== 0) begin failures++; $display("FAIL b2b_second_start: got %0d low cycles expected 0", o_rd_low); end
      tests++; if (o_addr !== line_base(a2)) begin failures++; $display("FAIL b2b_addr2: got %h expected %h", o_addr, line_base(a2)); end
      tests++; if (o_line !== l2) begin failures++; $display("FAIL b2b_line2: got %h expected %h", o_line, l2); end
      tests++; if (rd_count_o !== 32'(exp_rd)) begin failures++; $display("FAIL b2b_rd_count: got %0d expected %0d", rd_count_o, exp_rd); end
   endtask

   task automatic test_random();
      logic [31:0] a, o_addr, o_addr_done; logic [LW-1:0] lv, o_line, o_bursts, o_line_done; logic [BW-1:0] o_burst_done;
      int o_rd_low, o_resp_early, o_wr_low, o_rd_high; logic o_resp_done, o_rd_done, o_resp_after, o_rd_after, o_wr_done;
      int kind;
      for (int t = 0; t < 40; t++) begin
         a    = $urandom;
         lv   = rand_line();
         kind = $urandom_range(0, 2);
         if (kind == 0) begin
            run_read(a, lv, rand_gaps(), 1'b0, $urandom_range(0, 1) == 1, o_addr, o_rd_low, o_resp_early,
                     o_resp_done, o_rd_done, o_line, o_resp_after, o_rd_after);
            exp_rd++; last_line = lv;
            tests++; if (o_addr !== line_base(a)) begin failures++; $display("FAIL rnd_rd_addr[%0d]: got %h expected %h", t, o_addr, line_base(a)); end
            tests++; if (o_line !== lv) begin failures++; $display("FAIL rnd_rd_line[%0d]: got %h expected %h", t, o_line, lv); end
            tests++; if (o_rd_low !== 0 || o_resp_early !== 0 || o_resp_done !== 1'b1 || o_resp_after !== 1'b0) begin
               failures++; $display("FAIL rnd_rd_timing[%0d]: got rd_low=%0d early=%0d resp=%b after=%b expected 0 0 1 0",
                                    t, o_rd_low, o_resp_early, o_resp_done, o_resp_after);
            end
         end else begin
            run_write(a, lv, rand_gaps(), kind == 2, o_addr, o_bursts, o_wr_low, o_rd_high, o_resp_early,
                      o_resp_done, o_wr_done, o_addr_done, o_burst_done, o_line_done, o_resp_after);
            exp_wr++;
            tests++; if (o_addr !== line_base(a)) begin failures++; $display("FAIL rnd_wr_addr[%0d]: got %h expected %h", t, o_addr, line_base(a)); end
            tests++; if (o_bursts !== lv) begin failures++; $display("FAIL rnd_wr_bursts[%0d]: got %h expected %h", t, o_bursts, lv); end
            tests++; if (o_line_done !== last_line) begin failures++; $display("FAIL rnd_wr_line_kept[%0d]: got %h expected %h", t, o_line_done, last_line); end
            tests++; if (o_wr_low !== 0 || o_rd_high !== 0 || o_resp_early !== 0 || o_resp_done !== 1'b1 || o_resp_after !== 1'b0) begin
               failures++; $display("FAIL rnd_wr_timing[%0d]: got wr_low=%0d rd_high=%0d early=%0d resp=%b after=%b expected 0 0 0 1 0",
                                    t, o_wr_low, o_rd_high, o_resp_early, o_resp_done, o_resp_after);
            end
         end
         tests++; if (rd_count_o !== 32'(exp_rd) || wr_count_o !== 32'(exp_wr)) begin
            failures++; $display("FAIL rnd_counts[%0d]: got rd=%0d wr=%0d expected rd=%0d wr=%0d", t, rd_count_o, wr_count_o, exp_rd, exp_wr);
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      read_i    = 1'b0;
      write_i   = 1'b0;
      resp_i    = 1'b0;
      address_i = '0;
      line_i    = '0;
      burst_i   = '0;
      test_reset();
      test_read();
      test_write_gapped();
      test_simultaneous();
      test_stray_resp();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
